// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and lock FSM encoding shared by the VGA generator and decoder.
package vga_pkg;
  localparam int H_SYNC_PAUSE   = 96;
  localparam int H_BACK_PORCH   = 48;
  localparam int H_ACTIVE_TIME  = 640;
  localparam int H_LINE_PERIOD  = 800;
  localparam int V_SYNC_PAUSE   = 2;
  localparam int V_BACK_PORCH   = 33;
  localparam int V_ACTIVE_TIME  = 480;
  localparam int V_FRAME_PERIOD = 525;
  localparam int LOCK_FRAMES    = 2;
  localparam int H_ACT_START    = H_SYNC_PAUSE + H_BACK_PORCH;
  localparam int V_ACT_START    = V_SYNC_PAUSE + V_BACK_PORCH;
  localparam logic [11:0] CNT_MAX = 12'hFFF;
  typedef enum logic [1:0] {
    S_HUNT   = 2'b00,
    S_CHECK  = 2'b01,
    S_LOCKED = 2'b10
  } sync_state_t;
endpackage

// File: rtl/vga_edge_counter.sv
// vga_edge_counter: sync edge detection, line/frame position counters and period measurement.
module vga_edge_counter
  import vga_pkg::*;
(
  input  logic        clock_25Mhz,
  input  logic        reset,
  input  logic        H_sync,
  input  logic        V_sync,
  output logic        hfall,
  output logic        fstart,
  output logic        h_sat,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        frame_start,
  output logic [11:0] line_period,
  output logic [11:0] frame_lines
);
  logic h_prev, v_prev, vpend, vfall;
  assign hfall  = h_prev & ~H_sync;
  assign vfall  = v_prev & ~V_sync;
  // a vsync fall is held until the next hsync fall, which then defines line 0
  assign fstart = hfall & (vpend | vfall);
  assign h_sat  = (h_cnt == CNT_MAX) & ~hfall;
  always_ff @(posedge clock_25Mhz or negedge reset) begin
    if (!reset) begin
      h_prev      <= 1'b1;
      v_prev      <= 1'b1;
      vpend       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      line_period <= '0;
      frame_lines <= '0;
    end else begin
      h_prev      <= H_sync;
      v_prev      <= V_sync;
      frame_start <= fstart;
      vpend       <= fstart ? 1'b0 : (vpend | vfall);
      h_cnt       <= hfall ? '0 : (h_cnt == CNT_MAX ? h_cnt : h_cnt + 12'd1);
      if (hfall) begin
        line_period <= h_cnt + 12'd1;
        v_cnt       <= fstart ? '0 : (v_cnt == CNT_MAX ? v_cnt : v_cnt + 12'd1);
      end
      if (fstart) frame_lines <= v_cnt + 12'd1;
    end
  end
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, active strobe and timing lock from VGA syncs.
// Define VGA_DEC_CHECKSUM_EN to add a per-frame 16-bit sum of active pixels (frame_sum).
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_SYNC  = vga_pkg::H_SYNC_PAUSE,
  parameter int H_BP    = vga_pkg::H_BACK_PORCH,
  parameter int H_ACT   = vga_pkg::H_ACTIVE_TIME,
  parameter int H_LINE  = vga_pkg::H_LINE_PERIOD,
  parameter int V_SYNC  = vga_pkg::V_SYNC_PAUSE,
  parameter int V_BP    = vga_pkg::V_BACK_PORCH,
  parameter int V_ACT   = vga_pkg::V_ACTIVE_TIME,
  parameter int V_FRAME = vga_pkg::V_FRAME_PERIOD,
  parameter int LOCK_N  = vga_pkg::LOCK_FRAMES
) (
  input  logic        clock_25Mhz,
  input  logic        reset,
  input  logic        H_sync,
  input  logic        V_sync,
  input  logic [3:0]  in_red,
  input  logic [3:0]  in_green,
  input  logic [3:0]  in_blue,
  output logic [3:0]  pix_red,
  output logic [3:0]  pix_green,
  output logic [3:0]  pix_blue,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [11:0] line_period,
  output logic [11:0] frame_lines
`ifdef VGA_DEC_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);
  localparam logic [11:0] HA0 = 12'(H_SYNC + H_BP);
  localparam logic [11:0] HA1 = 12'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [11:0] VA0 = 12'(V_SYNC + V_BP);
  localparam logic [11:0] VA1 = 12'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [11:0] HL  = 12'(H_LINE);
  localparam logic [11:0] VF  = 12'(V_FRAME);
  localparam logic [3:0]  LOCK_C = 4'(LOCK_N - 1);
  logic        hfall, fstart, h_sat, frame_ok, skip, vis, line_bad, frame_good;
  logic [11:0] h_cnt, v_cnt;
  logic [3:0]  good_cnt;
  sync_state_t state;
  vga_edge_counter u_cnt (
    .clock_25Mhz (clock_25Mhz),
    .reset       (reset),
    .H_sync      (H_sync),
    .V_sync      (V_sync),
    .hfall       (hfall),
    .fstart      (fstart),
    .h_sat       (h_sat),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_start (frame_start),
    .line_period (line_period),
    .frame_lines (frame_lines)
  );
  assign vis        = (state == S_LOCKED) && h_cnt >= HA0 && h_cnt <= HA1 && v_cnt >= VA0 && v_cnt <= VA1;
  assign line_bad   = hfall & (h_cnt + 12'd1 != HL) & ~skip;
  assign frame_good = frame_ok & ~line_bad & (v_cnt + 12'd1 == VF);
  assign locked     = (state == S_LOCKED);
  // skip exempts the first line ending after leaving S_HUNT, whose start was never seen cleanly
  always_ff @(posedge clock_25Mhz or negedge reset) begin
    if (!reset) begin
      state    <= S_HUNT;
      good_cnt <= '0;
      frame_ok <= 1'b0;
      skip     <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      frame_ok <= fstart | (frame_ok & ~line_bad);
      skip     <= (state == S_HUNT) | (skip & ~hfall);
      if (h_sat) begin
        state    <= S_HUNT;
        sync_err <= (state == S_LOCKED);
      end else if (state == S_HUNT) begin
        if (fstart) begin
          state    <= S_CHECK;
          good_cnt <= '0;
        end
      end else if (state == S_CHECK) begin
        if (fstart && !frame_good) good_cnt <= '0;
        else if (fstart && good_cnt >= LOCK_C) state <= S_LOCKED;
        else if (fstart) good_cnt <= good_cnt + 4'd1;
      end else if (state == S_LOCKED) begin
        if (line_bad || (fstart && !frame_good)) begin
          state    <= S_HUNT;
          sync_err <= 1'b1;
        end
      end else begin
        state <= S_HUNT;
      end
    end
  end
  always_ff @(posedge clock_25Mhz or negedge reset) begin
    if (!reset) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pix_red     <= '0;
      pix_green   <= '0;
      pix_blue    <= '0;
    end else begin
      pixel_valid <= vis;
      pixel_x     <= vis ? 10'(h_cnt - HA0) : '0;
      pixel_y     <= vis ? 9'(v_cnt - VA0) : '0;
      pix_red     <= vis ? in_red : '0;
      pix_green   <= vis ? in_green : '0;
      pix_blue    <= vis ? in_blue : '0;
    end
  end
`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] acc;
  always_ff @(posedge clock_25Mhz or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      frame_sum <= '0;
    end else begin
      acc <= fstart ? '0 : acc + (vis ? {4'd0, in_red, in_green, in_blue} : 16'd0);
      if (fstart) frame_sum <= acc;
    end
  end
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized sync/pixel stream checked against an event-level lock model.
module tb_vga_sync_decoder;
  localparam int TH_SYNC = 4, TH_BP = 3, TH_ACT = 10, TH_LINE = 20;
  localparam int TV_SYNC = 2, TV_BP = 2, TV_ACT = 5, TV_FRAME = 10;
  localparam int TLOCK = 2;
  localparam int HA0 = TH_SYNC + TH_BP, HA1 = HA0 + TH_ACT - 1;
  localparam int VA0 = TV_SYNC + TV_BP, VA1 = VA0 + TV_ACT - 1;
  logic        clock_25Mhz = 1'b0;
  logic        reset, H_sync, V_sync;
  logic [3:0]  in_red, in_green, in_blue, pix_red, pix_green, pix_blue;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        pixel_valid, frame_start, locked, sync_err;
  logic [11:0] line_period, frame_lines;
`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] frame_sum;
`endif
  int total = 0, bad = 0, voff;
  always #5 clock_25Mhz = ~clock_25Mhz;
  vga_sync_decoder #(
    .H_SYNC(TH_SYNC), .H_BP(TH_BP), .H_ACT(TH_ACT), .H_LINE(TH_LINE),
    .V_SYNC(TV_SYNC), .V_BP(TV_BP), .V_ACT(TV_ACT), .V_FRAME(TV_FRAME), .LOCK_N(TLOCK)
  ) dut (
    .clock_25Mhz (clock_25Mhz),
    .reset       (reset),
    .H_sync      (H_sync),
    .V_sync      (V_sync),
    .in_red      (in_red),
    .in_green    (in_green),
    .in_blue     (in_blue),
    .pix_red     (pix_red),
    .pix_green   (pix_green),
    .pix_blue    (pix_blue),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err),
    .line_period (line_period),
    .frame_lines (frame_lines)
`ifdef VGA_DEC_CHECKSUM_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );
  // model: positions come from cycle stamps of sync falls, lock from a count of good frames
  int cyc, last_hf, line_no, mst, good, acc;
  bit hp, vp, vpend_m, clean, exempt;
  int e_valid, e_x, e_y, e_rgb, e_fs, e_err, e_lp, e_fl, e_sum;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    cyc = 0; last_hf = -1; line_no = 0; mst = 0; good = 0; acc = 0;
    hp = 1; vp = 1; vpend_m = 0; clean = 0; exempt = 0;
    e_valid = 0; e_x = 0; e_y = 0; e_rgb = 0; e_fs = 0; e_err = 0; e_lp = 0; e_fl = 0; e_sum = 0;
  endtask
  task automatic model_step();
    bit hf, vf, fs, badl, goodf, sat, vis;
    int hpos, vpos, len, rgbv, old;
    hf = hp && !H_sync;
    vf = vp && !V_sync;
    fs = hf && (vpend_m || vf);
    hpos = (cyc - last_hf - 1 > 4095) ? 4095 : cyc - last_hf - 1;
    vpos = line_no;
    len = (hpos + 1) % 4096;
    rgbv = in_red * 256 + in_green * 16 + in_blue;
    badl = hf && len != TH_LINE && !exempt;
    goodf = fs && clean && !badl && (vpos + 1) % 4096 == TV_FRAME;
    sat = hpos == 4095 && !hf;
    vis = mst == 2 && hpos >= HA0 && hpos <= HA1 && vpos >= VA0 && vpos <= VA1;
    e_valid = vis;
    e_x = vis ? hpos - HA0 : 0;
    e_y = vis ? vpos - VA0 : 0;
    e_rgb = vis ? rgbv : 0;
    e_fs = fs;
    e_err = 0;
    if (hf) e_lp = len;
    if (fs) e_fl = (vpos + 1) % 4096;
    if (fs) begin e_sum = acc; acc = 0; end
    else if (vis) acc = (acc + rgbv) % 65536;
    old = mst;
    if (sat) begin
      e_err = (mst == 2);
      mst = 0;
    end else if (mst == 0 && fs) begin
      mst = 1; good = 0;
    end else if (mst == 1 && fs) begin
      if (!goodf) good = 0;
      else begin
        good++;
        if (good >= TLOCK) mst = 2;
      end
    end else if (mst == 2 && (badl || (fs && !goodf))) begin
      mst = 0; e_err = 1;
    end
    exempt = (old == 0) || (exempt && !hf);
    clean = fs ? 1'b1 : (clean && !badl);
    line_no = fs ? 0 : (hf ? (line_no < 4095 ? line_no + 1 : 4095) : line_no);
    vpend_m = fs ? 1'b0 : (vpend_m || vf);
    if (hf) last_hf = cyc;
    hp = H_sync; vp = V_sync;
    cyc++;
  endtask
  task automatic step(input logic h, input logic v);
    H_sync = h; V_sync = v;
    in_red = 4'($urandom); in_green = 4'($urandom); in_blue = 4'($urandom);
    model_step();
    @(posedge clock_25Mhz);
    @(negedge clock_25Mhz);
    chk("pixel_valid", pixel_valid, e_valid);
    chk("pixel_x", pixel_x, e_x);
    chk("pixel_y", pixel_y, e_y);
    chk("pix_rgb", {pix_red, pix_green, pix_blue}, e_rgb);
    chk("frame_start", frame_start, e_fs);
    chk("locked", locked, mst == 2);
    chk("sync_err", sync_err, e_err);
    chk("line_period", line_period, e_lp);
    chk("frame_lines", frame_lines, e_fl);
`ifdef VGA_DEC_CHECKSUM_EN
    chk("frame_sum", frame_sum, e_sum);
`endif
  endtask
  task automatic drive_frame(input int sidx, input int slen);
    for (int l = 0; l < TV_FRAME; l++) begin
      int len;
      len = (l == sidx) ? slen : TH_LINE;
      for (int i = 0; i < len; i++)
        step(i >= TH_SYNC, !((l < TV_SYNC && (l > 0 || i >= voff)) || (l == TV_SYNC && i < voff)));
    end
  endtask
  task automatic check_zero();
    chk("rst_valid", pixel_valid, 0);
    chk("rst_xy", {pixel_x, pixel_y}, 0);
    chk("rst_rgb", {pix_red, pix_green, pix_blue}, 0);
    chk("rst_flags", {frame_start, locked, sync_err}, 0);
    chk("rst_meas", {line_period, frame_lines}, 0);
  endtask
  task automatic relock(input string tag);
    drive_frame(-1, 0);
    drive_frame(-1, 0);
    chk({tag, "_pre"}, locked, 0);
    drive_frame(-1, 0);
    chk(tag, locked, 1);
  endtask
  initial begin
    reset = 1'b0; H_sync = 1'b1; V_sync = 1'b1;
    in_red = '0; in_green = '0; in_blue = '0;
    voff = $urandom_range(0, 3);
    repeat (3) @(negedge clock_25Mhz);
    check_zero();
    reset = 1'b1;
    model_reset();
    repeat ($urandom_range(1, 20)) step(1'b1, 1'b1);
    relock("first_lock");
    chk("meas_line", line_period, TH_LINE);
    chk("meas_frame", frame_lines, TV_FRAME);
    drive_frame(-1, 0);
    drive_frame($urandom_range(1, TV_FRAME - 2),
                $urandom_range(0, 1) ? TH_LINE - 1 : TH_LINE + 1 + $urandom_range(0, 3));
    chk("short_line_unlock", locked, 0);
    relock("relock_short");
    repeat (4100) step(1'b1, 1'b1);
    chk("hold_unlock", locked, 0);
    chk("hold_valid", pixel_valid, 0);
    drive_frame(-1, 0);
    repeat (4100) step(1'b1, 1'b1);
    relock("relock_hold");
    for (int i = 0; i < TH_SYNC + 6; i++) step(i >= TH_SYNC, 1'b1);
    reset = 1'b0;
    #1;
    check_zero();
    @(negedge clock_25Mhz);
    reset = 1'b1;
    model_reset();
    relock("relock_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
